// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage with multi-cycle internal data memory.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_branch,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic        alu_zero,
  input  logic [31:0] alu_res,
  input  logic [31:0] rt_data,
  input  logic [4:0]  write_reg,
  input  logic [31:0] pc_branch,
  output logic        stall,
  output logic        out_valid,
  output logic        pc_src,
  output logic [31:0] out_pc_branch,
  output logic        out_reg_write,
  output logic        out_mem_to_reg,
  output logic [31:0] out_alu_res,
  output logic [31:0] out_read_data,
  output logic [4:0]  out_write_reg,
  output logic        misalign
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(LATENCY) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  logic        r_mem_read, r_mem_write, r_branch, r_reg_write, r_mem_to_reg, r_alu_zero;
  logic [31:0] r_alu_res, r_rt_data, r_pc_branch;
  logic [4:0]  r_write_reg;

  logic [31:0] mem [DEPTH];

  logic        in_wait;
  logic        mis_now;
  logic        done;
  logic        long_op;
  logic        sel_mem_read, sel_mem_write, sel_branch, sel_reg_write, sel_mem_to_reg, sel_zero;
  logic        sel_mis;
  logic [31:0] sel_alu_res, sel_rt_data, sel_pc_branch;
  logic [4:0]  sel_write_reg;
  logic [ADDR_W-1:0] sel_addr;
  logic        store_en;
  logic [31:0] rd_data;

  assign in_wait = (state == ST_WAIT);
  assign stall   = in_wait;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_now = (in_mem_read | in_mem_write) & (|alu_res[1:0]);
`else
  assign mis_now = 1'b0;
`endif

  // Completing ops come straight from the inputs in IDLE, from the stage register in WAIT.
  assign sel_mem_read   = in_wait ? r_mem_read   : in_mem_read;
  assign sel_mem_write  = in_wait ? r_mem_write  : in_mem_write;
  assign sel_branch     = in_wait ? r_branch     : in_branch;
  assign sel_reg_write  = in_wait ? r_reg_write  : in_reg_write;
  assign sel_mem_to_reg = in_wait ? r_mem_to_reg : in_mem_to_reg;
  assign sel_zero       = in_wait ? r_alu_zero   : alu_zero;
  assign sel_alu_res    = in_wait ? r_alu_res    : alu_res;
  assign sel_rt_data    = in_wait ? r_rt_data    : rt_data;
  assign sel_pc_branch  = in_wait ? r_pc_branch  : pc_branch;
  assign sel_write_reg  = in_wait ? r_write_reg  : write_reg;
  assign sel_mis        = in_wait ? 1'b0         : mis_now;
  assign sel_addr       = sel_alu_res[ADDR_W+1:2];

  always_comb begin
    done    = 1'b0;
    long_op = 1'b0;
    if (in_wait) begin
      done = (cnt == CNT_W'(1));
    end else if (in_valid) begin
      if ((in_mem_read | in_mem_write) && !mis_now && (LATENCY > 1)) begin
        long_op = 1'b1;
      end else begin
        done = 1'b1;
      end
    end
  end

  assign store_en = done & sel_mem_write & ~sel_mis;
  assign rd_data  = (sel_mem_read & ~sel_mem_write & ~sel_mis) ? mem[sel_addr] : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (long_op) begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(LATENCY - 1);
          end
        end
        default: begin
          cnt <= cnt - CNT_W'(1);
          if (done) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_zero   <= 1'b0;
      r_alu_res    <= 32'h0;
      r_rt_data    <= 32'h0;
      r_pc_branch  <= 32'h0;
      r_write_reg  <= 5'h0;
    end else if (!in_wait && in_valid) begin
      r_mem_read   <= in_mem_read;
      r_mem_write  <= in_mem_write;
      r_branch     <= in_branch;
      r_reg_write  <= in_reg_write;
      r_mem_to_reg <= in_mem_to_reg;
      r_alu_zero   <= alu_zero;
      r_alu_res    <= alu_res;
      r_rt_data    <= rt_data;
      r_pc_branch  <= pc_branch;
      r_write_reg  <= write_reg;
    end
  end

  // Array is not reset; rst_n gate keeps a store presented during reset from landing.
  always_ff @(posedge clk) begin
    if (rst_n && store_en) begin
      mem[sel_addr] <= sel_rt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      pc_src         <= 1'b0;
      out_pc_branch  <= 32'h0;
      out_reg_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_alu_res    <= 32'h0;
      out_read_data  <= 32'h0;
      out_write_reg  <= 5'h0;
    end else begin
      out_valid <= done;
      pc_src    <= done & sel_branch & sel_zero;
      if (done) begin
        out_pc_branch  <= sel_pc_branch;
        out_reg_write  <= sel_reg_write & ~sel_mis;
        out_mem_to_reg <= sel_mem_to_reg;
        out_alu_res    <= sel_alu_res;
        out_read_data  <= rd_data;
        out_write_reg  <= sel_write_reg;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= done & sel_mis;
    end
  end

  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int L     = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_mem_read, in_mem_write, in_branch, in_reg_write, in_mem_to_reg, alu_zero;
  logic [31:0] alu_res, rt_data, pc_branch;
  logic [4:0]  write_reg;
  logic        stall, out_valid, pc_src, out_reg_write, out_mem_to_reg, misalign;
  logic [31:0] out_pc_branch, out_alu_res, out_read_data;
  logic [4:0]  out_write_reg;

  mem_stage #(.DEPTH(DEPTH), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_branch(in_branch),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .alu_zero(alu_zero),
    .alu_res(alu_res), .rt_data(rt_data), .write_reg(write_reg), .pc_branch(pc_branch),
    .stall(stall), .out_valid(out_valid), .pc_src(pc_src), .out_pc_branch(out_pc_branch),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg), .out_alu_res(out_alu_res),
    .out_read_data(out_read_data), .out_write_reg(out_write_reg), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        rw, m2r, pcs, mis, rd_known;
    logic [31:0] alu, rd, pcb;
    logic [4:0]  wr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [int];
  int          st_lo = 1, st_hi = 0;
  int          n_chk = 0, n_pass = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Present one instruction, record what write-back must see, hold inputs through any stall.
  task automatic issue(input logic mr, input logic mw, input logic br, input logic rw,
                       input logic m2r, input logic z, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] wr, input logic [31:0] pcb);
    exp_t e;
    bit   mis;
    int   elat, idx;
    in_valid = 1'b1; in_mem_read = mr; in_mem_write = mw; in_branch = br;
    in_reg_write = rw; in_mem_to_reg = m2r; alu_zero = z;
    alu_res = alu; rt_data = rt; write_reg = wr; pc_branch = pcb;
    @(posedge clk); #1;
    mis  = ALN && (mr || mw) && (alu[1:0] != 2'b00);
    elat = ((mr || mw) && !mis) ? L : 1;
    idx  = int'((alu >> 2) % DEPTH);
    e.rd = 32'h0; e.rd_known = 1'b1;
    if (mw) begin
      if (!mis) mm[idx] = rt;
    end else if (mr && !mis) begin
      if (mm.exists(idx)) e.rd = mm[idx];
      else e.rd_known = 1'b0;
    end
    e.due = cyc + elat - 1;
    e.rw = rw && !mis; e.m2r = m2r; e.pcs = br && z; e.mis = mis;
    e.alu = alu; e.pcb = pcb; e.wr = wr;
    q.push_back(e);
    st_lo = cyc; st_hi = cyc + elat - 2;
    repeat (elat - 1) begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("missed_result", 32'(cyc), 32'(q[0].due));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_alu_res", out_alu_res, q[0].alu);
        chk("out_write_reg", 32'(out_write_reg), 32'(q[0].wr));
        chk("out_reg_write", 32'(out_reg_write), 32'(q[0].rw));
        chk("out_mem_to_reg", 32'(out_mem_to_reg), 32'(q[0].m2r));
        chk("out_pc_branch", out_pc_branch, q[0].pcb);
        chk("pc_src", 32'(pc_src), 32'(q[0].pcs));
        chk("misalign", 32'(misalign), 32'(q[0].mis));
        if (q[0].rd_known) chk("out_read_data", out_read_data, q[0].rd);
        void'(q.pop_front());
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
        chk("pc_src_idle", 32'(pc_src), 32'd0);
        chk("misalign_idle", 32'(misalign), 32'd0);
      end
      chk("stall", 32'(stall), 32'(cyc >= st_lo && cyc <= st_hi));
    end
  end

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_branch = 1'b0;
    in_reg_write = 1'b0; in_mem_to_reg = 1'b0; alu_zero = 1'b0;
    alu_res = 32'h0; rt_data = 32'h0; write_reg = 5'h0; pc_branch = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_outs", {out_valid, pc_src, out_reg_write, out_mem_to_reg, misalign, out_write_reg},
        32'd0);
    chk("rst_data", out_alu_res | out_read_data | out_pc_branch, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    //    mr   mw   br   rw   m2r  z    alu          rt            wr    pcb
    issue(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h10,      32'hDEADBEEF, 5'd0, 32'h0);
    issue(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,32'h10,      32'h0,        5'd8, 32'h0);
    chk("load_dead", out_read_data, 32'hDEADBEEF);
    chk("load_m2r", 32'(out_mem_to_reg), 32'd1);
    issue(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h1,       32'h0,        5'd1, 32'h0);
    issue(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h2,       32'h0,        5'd2, 32'h0);
    issue(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h3,       32'h0,        5'd3, 32'h0);
    chk("rtype3_alu", out_alu_res, 32'h3);
    issue(1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h0,       32'h0,        5'd0, 32'h40);
    chk("br_taken", {31'h0, pc_src}, 32'd1);
    chk("br_target", out_pc_branch, 32'h40);
    issue(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h5,       32'h0,        5'd0, 32'h40);
    chk("br_not_taken", {31'h0, pc_src}, 32'd0);
    issue(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h400,     32'h12345678, 5'd0, 32'h0);
    issue(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,       32'h0,        5'd9, 32'h0);
    chk("wrap_load", out_read_data, 32'h12345678);
    issue(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h30,      32'h0BADF00D, 5'd0, 32'h0);
    chk("rw_both_rd", out_read_data, 32'h0);
    issue(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,32'h30,      32'h0,        5'd4, 32'h0);
    chk("rw_both_load", out_read_data, 32'h0BADF00D);
    issue(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h20,      32'hCAFEF00D, 5'd0, 32'h0);

    // Store aborted by reset while the stage is stalled
    in_valid = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b1; in_branch = 1'b0;
    in_reg_write = 1'b0; alu_res = 32'h20; rt_data = 32'hBADBAD00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_outs", {out_valid, pc_src, out_reg_write, out_mem_to_reg, misalign, out_write_reg},
        32'd0);
    chk("abort_data", out_alu_res | out_read_data | out_pc_branch, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,32'h20,      32'h0,        5'd5, 32'h0);
    chk("abort_kept_old", out_read_data, 32'hCAFEF00D);

    issue(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h13,      32'h11111111, 5'd6, 32'h0);
    issue(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,32'h10,      32'h0,        5'd7, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
